mdu_scheduler: RTL and testbench
================================

# mdu_scheduler

Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts MDU operations from the E-stage decoder and latches operands. It models the fixed multiply and divide latencies with a busy counter, commits results into the architectural HI/LO registers, and raises a stall request for any MDU-class instruction in D while the unit is occupied. An exception/interrupt request (Req) suppresses new operations from the E-stage victim instruction.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- Req  input  1  exception/interrupt flush; E-stage instruction is a victim this cycle
- op_E  input  4  E-stage MDU op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; others = NONE
- A_E  input  32  forwarded rs value
- B_E  input  32  forwarded rt value
- md_D  input  1  D-stage instruction is any MDU-class op (ops 1–10)
- start  output  1  combinational; a multiply/divide is accepted this cycle
- busy  output  1  registered; operation in flight
- stall  output  1  combinational; md_D && (start || busy)
- muldivRes_E  output  32  combinational; HI for MFHI, LO for MFLO, else 0
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- Accept: start = (op_E ∈ {1,2,3,4,9,10}) && !busy && !Req. On accept, compute the 64-bit result into pending registers and load the counter with MULT_CYCLES or DIV_CYCLES.
- MULT/MULTU: pending {HI,LO} = signed/unsigned 32×32 product.
- DIV/DIVU: pending LO = quotient, HI = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. A divisor of 0 leaves pending = current {HI,LO}, so HI/LO are unchanged, but busy runs the full DIV_CYCLES.
- Counter decrements each cycle while nonzero. busy = (cnt != 0). When cnt == 1, HI/LO take the pending value on that edge.
- MTHI/MTLO: write A_E into HI/LO at the edge, only when !Req && !busy.
- MFHI/MFLO read the current HI/LO combinationally. The stall guarantees they never execute while busy.
- Req: blocks start and MTHI/MTLO for the current E instruction. An operation already in flight completes and commits normally, because its instruction has already passed the exception point.
- An MDU op in E while busy cannot occur (stall). If it does occur, it is ignored; the bench asserts on it.

## Timing
- Reset values: HI=0, LO=0, busy=0, cnt=0, pending=0. start/stall/muldivRes_E follow their inputs.
- MULT accepted in cycle t: busy=1 in cycles t+1..t+5, HI/LO update at the end of t+5, busy=0 in t+6. An MFHI in E at t+6 sees the new value.
- DIV in cycle t: busy in cycles t+1..t+10, commit at the end of t+10.
- stall is asserted in cycle t (start) and every busy cycle while md_D=1. Non-MDU D instructions are never stalled.
- Back-to-back: a MULT following in D stalls until busy falls, then issues in the cycle after busy=0. Zero dead cycles beyond the latency.
- Asynchronous reset mid-operation: cnt, busy, HI, LO and pending clear immediately, and no commit occurs.
- A Req in the same cycle as the final-count edge still allows the commit.

## Configuration
- MDU_MADD_EN defined: ops 9/10 are accepted with MULT_CYCLES latency. pending = {HI,LO} + signed/unsigned product, mod 2^64, sampled from HI/LO at accept.
- MDU_MADD_EN undefined: ops 9/10 decode as NONE. No start, no write, and md_D remains the decoder's responsibility.

## Test plan
- Reset, then MULT A=0xFFFFFFFF B=2 -> busy cycles 1..5, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU on the same operands -> HI=1, LO=0xFFFFFFFE.
- DIV A=-7 B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=5 B=0 -> HI/LO unchanged, busy for 10 cycles.
- MULT followed immediately by MFLO in D -> stall=1 for 6 cycles, then MFLO returns the product on its first E cycle.
- MTHI 0x1234 with Req=1 -> HI unchanged. MULT with Req=1 -> start=0, busy stays 0.
- DIV in flight, Req pulse at cycle 4 -> commit still occurs at cycle 10. Async reset at cycle 4 of a MULT -> HI=LO=0 and busy=0 immediately.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 -> HI=1, LO=0. Without MDU_MADD_EN: op 9 -> no start, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_scheduler_if.sv
// E-stage <-> multiply/divide scheduler bundle: decoded op, operands, flush, stall and HI/LO results.
interface mdu_scheduler_if;
    logic        Req;
    logic [3:0]  op_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        md_D;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] muldivRes_E;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Req, op_E, A_E, B_E, md_D,
        input  start, busy, stall, muldivRes_E, HI, LO
    );

    modport slave (
        input  Req, op_E, A_E, B_E, md_D,
        output start, busy, stall, muldivRes_E, HI, LO
    );
endinterface

// File: rtl/mdu_scheduler.sv
// Multi-cycle MULT/DIV sequencer with HI/LO commit and D-stage stall generation.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mdu_scheduler_if.slave bus
);
    localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef MDU_MADD_EN
    localparam int OP_TOP = 10;
`else
    localparam int OP_TOP = 8;
`endif

    logic [OP_TOP:1] op_hot;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0]      pending_reg;
    logic [63:0]      pending_next;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    logic is_mul, is_div, is_madd, signed_op, busy_int, start_int;

    generate
        for (genvar gi = 1; gi <= OP_TOP; gi++) begin : g_dec
            assign op_hot[gi] = (bus.op_E == 4'(gi));
        end
    endgenerate

    assign is_div = op_hot[3] | op_hot[4];
`ifdef MDU_MADD_EN
    assign is_mul    = op_hot[1] | op_hot[2];
    assign is_madd   = op_hot[9] | op_hot[10];
    assign signed_op = op_hot[1] | op_hot[3] | op_hot[9];
`else
    assign is_mul    = op_hot[1] | op_hot[2];
    assign is_madd   = 1'b0;
    assign signed_op = op_hot[1] | op_hot[3];
`endif

    assign busy_int  = (cnt_reg != '0);
    assign start_int = (is_mul | is_div | is_madd) & ~busy_int & ~bus.Req;

    // One multiplier serves both signednesses: sign-extend to 64 bits and keep the low half.
    logic [63:0] ext_a, ext_b, product;
    assign ext_a   = {{32{signed_op & bus.A_E[31]}}, bus.A_E};
    assign ext_b   = {{32{signed_op & bus.B_E[31]}}, bus.B_E};
    assign product = ext_a * ext_b;

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
    assign a_neg   = signed_op & bus.A_E[31];
    assign b_neg   = signed_op & bus.B_E[31];
    assign a_mag   = a_neg ? (~bus.A_E + 32'd1) : bus.A_E;
    assign b_mag   = b_neg ? (~bus.B_E + 32'd1) : bus.B_E;
    assign div_den = (bus.B_E == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / div_den;
    assign r_mag   = a_mag % div_den;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        pending_next = {hi_reg, lo_reg};
        if (is_div) begin
            if (bus.B_E != 32'd0)
                pending_next = {rem, quot};
        end else if (is_mul) begin
            pending_next = product;
        end else if (is_madd) begin
            pending_next = {hi_reg, lo_reg} + product;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            pending_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            if (start_int) begin
                pending_reg <= pending_next;
                cnt_reg     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (busy_int) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end

            // The in-flight op is past the exception point, so Req does not gate the commit.
            if (cnt_reg == CNT_W'(1)) begin
                hi_reg <= pending_reg[63:32];
                lo_reg <= pending_reg[31:0];
            end else if (!busy_int && !bus.Req) begin
                if (op_hot[7]) hi_reg <= bus.A_E;
                if (op_hot[8]) lo_reg <= bus.A_E;
            end
        end
    end

    assign bus.start       = start_int;
    assign bus.busy        = busy_int;
    assign bus.stall       = bus.md_D & (start_int | busy_int);
    assign bus.muldivRes_E = op_hot[5] ? hi_reg : (op_hot[6] ? lo_reg : 32'd0);
    assign bus.HI          = hi_reg;
    assign bus.LO          = lo_reg;
endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed self-checking bench for mdu_scheduler: latency, HI/LO results, stall, Req and reset behaviour.
module tb_mdu_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_scheduler_if bus();
    mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req, input logic md);
        bus.op_E = op; bus.A_E = a; bus.B_E = b; bus.Req = req; bus.md_D = md;
        #1;
    endtask

    // Issue one op, then idle for cyc cycles counting busy; ends in the cycle after the window.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cyc, output int nbusy);
        drive(op, a, b, 1'b0, 1'b0);
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        nbusy = 0;
        for (int i = 0; i < cyc; i++) begin
            if (bus.busy) nbusy++;
            step();
        end
        $display("txn op=%0d A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", op, a, b, bus.HI, bus.LO, nbusy);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); step();
        checks++; if (bus.HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", bus.HI, 32'd0); end
        checks++; if (bus.LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", bus.LO, 32'd0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.start); end
        reset = 1'b0;
        step();
        $display("txn reset released");
    endtask

    task automatic test_mult();
        int nb;
        drive(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        checks++; if (bus.start !== 1'b1) begin failures++; $display("FAIL mult_start got=%b exp=1", bus.start); end
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mult_busy_c%0d got=%b exp=1", i, bus.busy); end
            if (i == 5) begin
                checks++; if (bus.LO !== 32'd0) begin failures++; $display("FAIL mult_early_commit got=%h exp=%h", bus.LO, 32'd0); end
            end
            step();
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mult_busy_end got=%b exp=0", bus.busy); end
        checks++; if (bus.HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", bus.HI, 32'hFFFF_FFFF); end
        checks++; if (bus.LO !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_lo got=%h exp=%h", bus.LO, 32'hFFFF_FFFE); end
        $display("txn MULT FFFFFFFF*2 -> HI=%h LO=%h", bus.HI, bus.LO);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5, nb);
        checks++; if (nb !== 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", nb); end
        checks++; if (bus.HI !== 32'd1) begin failures++; $display("FAIL multu_hi got=%h exp=%h", bus.HI, 32'd1); end
        checks++; if (bus.LO !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=%h", bus.LO, 32'hFFFF_FFFE); end
    endtask

    task automatic test_div();
        int nb;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, nb);
        checks++; if (nb !== 10 || bus.busy !== 1'b0) begin failures++; $display("FAIL div_busy got=%0d/%b exp=10/0", nb, bus.busy); end
        checks++; if (bus.LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=%h", bus.LO, 32'hFFFF_FFFD); end
        checks++; if (bus.HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=%h", bus.HI, 32'hFFFF_FFFF); end
        run_op(4'd3, 32'd5, 32'd0, 10, nb);
        checks++; if (nb !== 10 || bus.busy !== 1'b0) begin failures++; $display("FAIL div0_busy got=%0d/%b exp=10/0", nb, bus.busy); end
        checks++; if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div0_keep got=%h exp=%h", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, nb);
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=%h", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000); end
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 10, nb);
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_0001_7FFF_FFFC) begin failures++; $display("FAIL divu got=%h exp=%h", {bus.HI, bus.LO}, 64'h0000_0001_7FFF_FFFC); end
    endtask

    task automatic test_stall();
        int nst;
        int nb;
        drive(4'd1, 32'd3, 32'd5, 1'b0, 1'b1);
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.stall) nst++;
            step();
            drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        checks++; if (nst !== 6) begin failures++; $display("FAIL stall_cycles got=%0d exp=6", nst); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", bus.stall); end
        drive(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.muldivRes_E !== 32'd15) begin failures++; $display("FAIL mflo_res got=%h exp=%h", bus.muldivRes_E, 32'd15); end
        drive(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.muldivRes_E !== 32'd0) begin failures++; $display("FAIL mfhi_res got=%h exp=%h", bus.muldivRes_E, 32'd0); end
        $display("txn MULT 3*5 then MFLO -> stall_cycles=%0d LO=%h", nst, bus.LO);
        // Back-to-back MULT, with a non-MDU op sitting in D during the busy window.
        drive(4'd1, 32'd4, 32'd6, 1'b0, 1'b1);
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL nonmdu_stall got=%b exp=0", bus.stall); end
        repeat (5) step();
        drive(4'd1, 32'd7, 32'd8, 1'b0, 1'b0);
        checks++; if (bus.start !== 1'b1) begin failures++; $display("FAIL b2b_start got=%b exp=1", bus.start); end
        checks++; if (bus.LO !== 32'd24) begin failures++; $display("FAIL b2b_first got=%h exp=%h", bus.LO, 32'd24); end
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        nb = 0;
        for (int i = 0; i < 5; i++) begin if (bus.busy) nb++; step(); end
        checks++; if (bus.LO !== 32'd56 || nb !== 5) begin failures++; $display("FAIL b2b_second got=%h/%0d exp=%h/5", bus.LO, nb, 32'd56); end
        $display("txn back-to-back MULT 4*6, 7*8 -> LO=%h", bus.LO);
    endtask

    task automatic test_req();
        drive(4'd7, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0); step();
        drive(4'd8, 32'h0000_5555, 32'd0, 1'b0, 1'b0); step();
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_AAAA_0000_5555) begin failures++; $display("FAIL mthi_mtlo got=%h exp=%h", {bus.HI, bus.LO}, 64'h0000_AAAA_0000_5555); end
        drive(4'd7, 32'h0000_1234, 32'd0, 1'b1, 1'b0); step();
        drive(4'd8, 32'h0000_1234, 32'd0, 1'b1, 1'b0); step();
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_AAAA_0000_5555) begin failures++; $display("FAIL req_mt got=%h exp=%h", {bus.HI, bus.LO}, 64'h0000_AAAA_0000_5555); end
        drive(4'd1, 32'd2, 32'd2, 1'b1, 1'b0);
        checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL req_start got=%b exp=0", bus.start); end
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL req_busy got=%b exp=0", bus.busy); end
        repeat (6) step();
        checks++; if (bus.LO !== 32'h0000_5555) begin failures++; $display("FAIL req_nocommit got=%h exp=%h", bus.LO, 32'h0000_5555); end
        $display("txn Req blocks MTHI/MTLO/MULT -> HI=%h LO=%h", bus.HI, bus.LO);
    endtask

    task automatic test_req_inflight();
        drive(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(4'd0, 32'd0, 32'd0, (i == 4 || i == 10), 1'b0);
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_0002_0000_000E) begin failures++; $display("FAIL req_inflight got=%h exp=%h", {bus.HI, bus.LO}, 64'h0000_0002_0000_000E); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL req_inflight_busy got=%b exp=0", bus.busy); end
        $display("txn DIV 100/7 with Req at c4,c10 -> HI=%h LO=%h", bus.HI, bus.LO);
    endtask

    task automatic test_async_reset();
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) step();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.HI, bus.LO} !== 65'd0) begin failures++; $display("FAIL arst_clear got=%b/%h/%h exp=0/0/0", bus.busy, bus.HI, bus.LO); end
        step();
        reset = 1'b0;
        repeat (4) step();
        checks++; if ({bus.busy, bus.HI, bus.LO} !== 65'd0) begin failures++; $display("FAIL arst_nocommit got=%b/%h/%h exp=0/0/0", bus.busy, bus.HI, bus.LO); end
        $display("txn async reset mid-MULTU -> HI=%h LO=%h", bus.HI, bus.LO);
    endtask

    task automatic test_madd();
        int nb;
`ifdef MDU_MADD_EN
        drive(4'd7, 32'd0, 32'd0, 1'b0, 1'b0); step();
        drive(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0); step();
        run_op(4'd10, 32'd1, 32'd1, 5, nb);
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_0001_0000_0000 || nb !== 5) begin failures++; $display("FAIL maddu got=%h/%0d exp=%h/5", {bus.HI, bus.LO}, nb, 64'h0000_0001_0000_0000); end
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 5, nb);
        checks++; if ({bus.HI, bus.LO} !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL madd got=%h exp=%h", {bus.HI, bus.LO}, 64'h0000_0000_FFFF_FFFF); end
`else
        drive(4'd7, 32'h11, 32'd0, 1'b0, 1'b0); step();
        drive(4'd8, 32'h22, 32'd0, 1'b0, 1'b0); step();
        drive(4'd9, 32'd1, 32'd1, 1'b0, 1'b0);
        checks++; if (bus.start !== 1'b0) begin failures++; $display("FAIL madd_off_start got=%b exp=0", bus.start); end
        run_op(4'd10, 32'd1, 32'd1, 5, nb);
        checks++; if (nb !== 0 || {bus.HI, bus.LO} !== 64'h0000_0011_0000_0022) begin failures++; $display("FAIL madd_off got=%h/%0d exp=%h/0", {bus.HI, bus.LO}, nb, 64'h0000_0011_0000_0022); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_req();
        test_req_inflight();
        test_async_reset();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
